muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
Sequencing controller for the HI/LO arithmetic resource next to the execute stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from EXE and runs a 2-cycle multiply or a 32-iteration restoring divide. It owns the architectural HI/LO registers and raises stall_req to freeze the pipeline while an operation is in flight.

Parameters:
DATA_W, 32, operand/HI/LO width; the divide iteration count equals DATA_W.

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  request valid; EXE holds start/op/src_a/src_b stable while stall_req=1
op  in  3  operation code (muldiv_pkg)
src_a  in  DATA_W  rs operand (dividend / multiplicand / MTHI-MTLO data)
src_b  in  DATA_W  rt operand (divisor / multiplier)
cancel  in  1  flush from exception/branch logic; aborts any operation
stall_req  out  1  pipeline stall request
busy  out  1  FSM not in IDLE
done  out  1  one-cycle pulse; HI/LO already hold the new result
hi_out  out  DATA_W  architectural HI
lo_out  out  DATA_W  architectural LO

Behaviour:
- Reset (rst=1 at edge): state=IDLE, cnt=0, hi_out=0, lo_out=0, done=0, busy=0, stall_req=0. A reset mid-operation discards the result.
- Op codes: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6. Codes 7 and NOP are ignored.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE transitions:
  - start and MTHI/MTLO: write hi/lo at the edge; stay IDLE; no stall; no done.
  - start and MULT/MULTU: latch operands, go to MUL.
  - start and DIV/DIVU: latch magnitudes (signed ops take |x|), cnt=0, go to DIV.
  - DIV/DIVU with src_b=0: go directly to DONE with lo=all-ones and hi=src_a.
- MUL: compute the 64-bit product (signed or unsigned), write {hi,lo}, go to DONE.
- DIV:
  - One restoring iteration per cycle; cnt increments.
  - At cnt=DATA_W-1: apply sign fixup, write lo=quotient and hi=remainder, go to DONE.
  - Sign rules: quotient negative iff a[31]^b[31]; remainder takes the sign of the dividend.
- DONE: done=1 for one cycle; stall_req=0 so the pipeline advances. start may still be high and is ignored. Next state is IDLE.
- stall_req (combinational) = ((state==IDLE and start and op in {MULT,MULTU,DIV,DIVU}) or state==MUL or state==DIV) and not cancel.
- Latency, counting the cycle start is first seen as cycle 0:
  - MUL: stall in cycles 0–1, done in cycle 2.
  - DIV: stall in cycles 0–32, done in cycle 33.
  - Divide-by-zero: done in cycle 1.
- cancel has priority over everything except rst:
  - Next state is IDLE, cnt=0, and HI/LO are not written.
  - cancel in DONE is too late; HI/LO keep the result.
  - cancel together with MTHI/MTLO in IDLE suppresses the write.
- busy = (state != IDLE).

Decomposition:
- muldiv_pkg holds the op code localparams (MD_NOP..MD_MTLO) and the FSM state encoding (IDLE/MUL/DIV/DONE, 2 bits).
- Sub-module div_iter: remainder/quotient shift registers, one iteration per enable, with a sign-fixup output. muldiv_ctrl instantiates it and drives its enable from the FSM.
- The multiply is inline (a single registered product).

Test Plan:
1. MULT src_a=0xFFFFFFFD (-3), src_b=5 -> stall_req in cycles 0–1, done in cycle 2, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
2. MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done in cycle 2.
3. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, done in cycle 33. DIVU 7/2 -> lo=3, hi=1, stall_req high for exactly 33 cycles.
4. DIV 0x12345678/0 -> done in cycle 1, lo=0xFFFFFFFF, hi=0x12345678.
5. Preload hi=0xAAAA via MTHI, start DIVU 100/3, assert cancel in cycle 10:
   - stall_req=0 that cycle and busy=0 next cycle;
   - hi=0xAAAA unchanged and no done pulse;
   - a repeated rst=1 in cycle 5 of a new DIV gives hi=lo=0 and IDLE.
6. MTHI 0x1234 then MTLO 0x5678 on consecutive cycles in IDLE -> no stall, hi=0x1234 and lo=0x5678 after each edge, done never asserted.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide controller.
//   MD_* : operation codes presented on op by EXE
//   state_e : controller FSM encoding
package muldiv_pkg;

  localparam logic [2:0] MD_NOP   = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// EXE <-> muldiv_ctrl bundle.
//   master (EXE): drives start/op/src_a/src_b/cancel, sees stall/busy/done/HI/LO
//   slave  (controller): the reverse
interface muldiv_ctrl_if #(parameter int DATA_W = 32);
  logic              start;
  logic [2:0]        op;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              cancel;
  logic              stall_req;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi_out;
  logic [DATA_W-1:0] lo_out;

  modport master (output start, op, src_a, src_b, cancel,
                  input  stall_req, busy, done, hi_out, lo_out);
  modport slave  (input  start, op, src_a, src_b, cancel,
                  output stall_req, busy, done, hi_out, lo_out);
endinterface

// File: rtl/muldiv_ctrl_div_iter.sv
// Restoring divider datapath, one quotient bit per enabled cycle.
//   clk, rst    : clock, synchronous active-high reset
//   load_i      : capture operand magnitudes and result signs
//   en_i        : perform one iteration
//   signed_i    : treat a_i/b_i as two's complement
//   a_i, b_i    : dividend, divisor (b_i must be non-zero)
//   q_o, r_o    : sign-fixed quotient/remainder *after* the current iteration,
//                 so the controller can commit them on the final enable edge
module div_iter #(parameter int DATA_W = 32) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              en_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] q_o,
  output logic [DATA_W-1:0] r_o
);
  logic [DATA_W-1:0] rem_q, quo_q, dvs_q;
  logic              qneg_q, rneg_q;

  logic              a_neg, b_neg;
  logic [DATA_W-1:0] a_mag, b_mag;
  assign a_neg = signed_i & a_i[DATA_W-1];
  assign b_neg = signed_i & b_i[DATA_W-1];
  assign a_mag = a_neg ? -a_i : a_i;
  assign b_mag = b_neg ? -b_i : b_i;

  // quo_q starts as the dividend and shifts out MSB-first while quotient
  // bits shift in at the bottom.
  logic [DATA_W:0]   shifted, diff;
  logic              ge;
  logic [DATA_W-1:0] rem_n, quo_n;
  assign shifted = {rem_q, quo_q[DATA_W-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign ge      = ~diff[DATA_W];
  assign rem_n   = ge ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
  assign quo_n   = {quo_q[DATA_W-2:0], ge};

  assign q_o = qneg_q ? -quo_n : quo_n;
  assign r_o = rneg_q ? -rem_n : rem_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else if (load_i) begin
      rem_q  <= '0;
      quo_q  <= a_mag;
      dvs_q  <= b_mag;
      qneg_q <= a_neg ^ b_neg;
      rneg_q <= a_neg;
    end else if (en_i) begin
      rem_q  <= rem_n;
      quo_q  <= quo_n;
    end
  end
endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO sequencing controller beside EXE: 2-cycle multiply, DATA_W-iteration
// restoring divide, MTHI/MTLO writes; owns HI/LO and stalls the pipe.
//   clk, rst : clock, synchronous active-high reset
//   bus      : muldiv_ctrl_if slave (start/op/src_a/src_b/cancel in;
//              stall_req/busy/done/hi_out/lo_out out)
module muldiv_ctrl import muldiv_pkg::*; #(parameter int DATA_W = 32) (
  input logic           clk,
  input logic           rst,
  muldiv_ctrl_if.slave  bus
);
  localparam int CW = $clog2(DATA_W);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [DATA_W-1:0] ma_q, ma_d, mb_q, mb_d;
  logic              msgn_q, msgn_d;
  logic              div_load, div_en;
  logic [DATA_W-1:0] div_q, div_r;

  logic is_mul, is_div;
  assign is_mul = (bus.op == MD_MULT) || (bus.op == MD_MULTU);
  assign is_div = (bus.op == MD_DIV)  || (bus.op == MD_DIVU);

  // Sign-extend to 2*DATA_W so one modular multiply covers both signednesses.
  logic [2*DATA_W-1:0] a_ext, b_ext, prod;
  assign a_ext = {{DATA_W{msgn_q & ma_q[DATA_W-1]}}, ma_q};
  assign b_ext = {{DATA_W{msgn_q & mb_q[DATA_W-1]}}, mb_q};
  assign prod  = a_ext * b_ext;

  div_iter #(.DATA_W(DATA_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .load_i   (div_load),
    .en_i     (div_en),
    .signed_i (bus.op == MD_DIV),
    .a_i      (bus.src_a),
    .b_i      (bus.src_b),
    .q_o      (div_q),
    .r_o      (div_r)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    msgn_d   = msgn_q;
    div_load = 1'b0;
    div_en   = 1'b0;
    case (state_q)
      IDLE: if (bus.start && !bus.cancel) begin
        if (bus.op == MD_MTHI) hi_d = bus.src_a;
        else if (bus.op == MD_MTLO) lo_d = bus.src_a;
        else if (is_mul) begin
          ma_d    = bus.src_a;
          mb_d    = bus.src_b;
          msgn_d  = (bus.op == MD_MULT);
          state_d = MUL;
        end else if (is_div) begin
          if (bus.src_b == '0) begin
            lo_d    = '1;
            hi_d    = bus.src_a;
            state_d = DONE;
          end else begin
            div_load = 1'b1;
            cnt_d    = '0;
            state_d  = DIV;
          end
        end
      end
      MUL: begin
        if (bus.cancel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          {hi_d, lo_d} = prod;
          state_d      = DONE;
        end
      end
      DIV: begin
        if (bus.cancel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          div_en = 1'b1;
          cnt_d  = cnt_q + CW'(1);
          // Final iteration: commit the post-iteration result directly.
          if (cnt_q == CW'(DATA_W-1)) begin
            hi_d    = div_r;
            lo_d    = div_q;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      msgn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      msgn_q  <= msgn_d;
    end
  end

  assign bus.stall_req = ((state_q == IDLE && bus.start && (is_mul || is_div)) ||
                          state_q == MUL || state_q == DIV) && !bus.cancel;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.hi_out    = hi_q;
  assign bus.lo_out    = lo_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_ctrl_if #(.DATA_W(W)) bus();
  muldiv_ctrl #(.DATA_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          issue_cyc = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: architectural result from plain arithmetic.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] hi_in, input logic [31:0] lo_in,
                                output logic [31:0] hi, output logic [31:0] lo, output int lat);
    longint          p, sa, sd, q, r;
    longint unsigned up;
    hi = hi_in; lo = lo_in; lat = 0;
    case (op)
      3'd1: begin p = longint'($signed(a)) * longint'($signed(b)); hi = p[63:32]; lo = p[31:0]; lat = 2; end
      3'd2: begin up = {32'b0, a} * {32'b0, b}; hi = up[63:32]; lo = up[31:0]; lat = 2; end
      3'd3, 3'd4: begin
        if (b == 0) begin
          hi = a; lo = 32'hFFFF_FFFF; lat = 1;
        end else if (op == 3'd3) begin
          sa = longint'($signed(a)); sd = longint'($signed(b));
          q = sa / sd; r = sa % sd;
          lo = q[31:0]; hi = r[31:0]; lat = 33;
        end else begin
          lo = a / b; hi = a % b; lat = 33;
        end
      end
      3'd5: hi = a;
      3'd6: lo = a;
      default: ;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done: got done=1 want no pulse (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("done_hi", bus.hi_out, e.hi);
        chk("done_lo", bus.lo_out, e.lo);
        chk("done_latency", cyc - issue_cyc, e.lat);
      end
    end
  end

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] nh, nl;
    int          lat, stalls;
    bit          seen;
    model(op, a, b, m_hi, m_lo, nh, nl, lat);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
    issue_cyc = cyc;
    if (op >= 3'd1 && op <= 3'd4) begin
      sb.push_back('{nh, nl, lat});
      stalls = 0; seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clk);
        if (bus.stall_req) stalls++;
        if (bus.done) seen = 1;
      end
      if (!seen) begin
        tests++; fails++;
        $display("FAIL done_timeout: got no done want done within 100 cycles (op %0d)", op);
      end
      chk("stall_cycles", stalls, lat);
      @(posedge clk); #1;
      bus.start = 1'b0;
    end else begin
      @(negedge clk);
      chk("no_stall", bus.stall_req, 0);
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(negedge clk);
      chk("idle_hi", bus.hi_out, nh);
      chk("idle_lo", bus.lo_out, nl);
      chk("idle_busy", bus.busy, 0);
    end
    m_hi = nh; m_lo = nl;
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    bus.start = 0; bus.op = '0; bus.src_a = '0; bus.src_b = '0; bus.cancel = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_stall", bus.stall_req, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_hi", bus.hi_out, 0);
    chk("rst_lo", bus.lo_out, 0);

    // Directed cases
    do_op(3'd1, 32'hFFFF_FFFD, 32'd5);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(3'd3, 32'hFFFF_FFF9, 32'd2);
    do_op(3'd4, 32'd7, 32'd2);
    do_op(3'd3, 32'h1234_5678, 32'd0);
    do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(3'd3, 32'd7, 32'hFFFF_FFFE);

    // MTHI then MTLO on back-to-back cycles
    @(posedge clk); #1;
    bus.start = 1; bus.op = 3'd5; bus.src_a = 32'h1234; bus.src_b = 0;
    @(negedge clk); chk("mt_stall0", bus.stall_req, 0);
    @(posedge clk); #1;
    bus.op = 3'd6; bus.src_a = 32'h5678;
    @(negedge clk);
    chk("mthi_hi", bus.hi_out, 32'h1234);
    chk("mt_stall1", bus.stall_req, 0);
    @(posedge clk); #1;
    bus.start = 0;
    @(negedge clk);
    chk("mtlo_hi", bus.hi_out, 32'h1234);
    chk("mtlo_lo", bus.lo_out, 32'h5678);
    m_hi = 32'h1234; m_lo = 32'h5678;

    // Cancel in cycle 10 of DIVU 100/3 after preloading HI
    do_op(3'd5, 32'hAAAA, 32'd0);
    @(posedge clk); #1;
    bus.start = 1; bus.op = 3'd4; bus.src_a = 32'd100; bus.src_b = 32'd3;
    repeat (10) @(posedge clk);
    #1 bus.cancel = 1;
    @(negedge clk);
    chk("cancel_stall", bus.stall_req, 0);
    chk("cancel_busy_before", bus.busy, 1);
    @(posedge clk); #1;
    bus.cancel = 0; bus.start = 0;
    @(negedge clk);
    chk("cancel_busy_after", bus.busy, 0);
    chk("cancel_hi", bus.hi_out, 32'hAAAA);
    chk("cancel_lo", bus.lo_out, m_lo);
    repeat (40) @(posedge clk);

    // Cancel with MTHI in IDLE suppresses the write
    #1;
    bus.start = 1; bus.op = 3'd5; bus.src_a = 32'h5555; bus.cancel = 1;
    @(negedge clk); chk("cancel_mthi_stall", bus.stall_req, 0);
    @(posedge clk); #1;
    bus.start = 0; bus.cancel = 0;
    @(negedge clk); chk("cancel_mthi_hi", bus.hi_out, m_hi);

    // Reset in cycle 5 of a DIV
    @(posedge clk); #1;
    bus.start = 1; bus.op = 3'd3; bus.src_a = 32'd1000; bus.src_b = 32'd7;
    repeat (5) @(posedge clk);
    #1 rst = 1; bus.start = 0;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("midrst_hi", bus.hi_out, 0);
    chk("midrst_lo", bus.lo_out, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    m_hi = 0; m_lo = 0;

    // Randomized mix
    for (int n = 0; n < 50; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if ($urandom_range(0, 9) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      do_op(rop, ra, rb);
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
